// File: rtl/adc_capture_trig_if.sv
// Capture-port bundle between the acquisition front end and the trigger/record block.
// Latency: none, wires only; timing belongs to the endpoints.
// Backpressure: none; samples are strobed in, and the record is read by random access.
//
// Signals:
//   samp_clk, adc_data                   sample strobe and ADC word (front end -> capture)
//   arm, trig_level, trig_slope, force_trig  capture control
//   busy, triggered, done                capture status (capture -> controller)
//   rd_addr, rd_data                     record read port, one-cycle read latency
interface adc_capture_trig_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
);
   logic              samp_clk;
   logic [DATA_W-1:0] adc_data;
   logic              arm;
   logic [DATA_W-1:0] trig_level;
   logic              trig_slope;
   logic              force_trig;
   logic              busy;
   logic              triggered;
   logic              done;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   // Controller / front-end side.
   modport master (
      output samp_clk, adc_data, arm, trig_level, trig_slope, force_trig, rd_addr,
      input  busy, triggered, done, rd_data
   );

   // Capture engine side.
   modport slave (
      input  samp_clk, adc_data, arm, trig_level, trig_slope, force_trig, rd_addr,
      output busy, triggered, done, rd_data
   );
endinterface

// File: rtl/adc_capture_trig.sv
// Ring-buffer ADC capture with pre-trigger history, level/slope trigger, and a frozen record readout.
// Latency: status flags are registered one sys_clk after the causing strobe/arm; rd_data follows rd_addr by one cycle.
// Backpressure: none; the ADC is sampled on every samp_clk rising edge, and the record is read at will.
//
// Ports:
//   sys_clk  single clock domain
//   rst      synchronous, active-high; aborts any capture to IDLE (buffer contents retained)
//   bus      adc_capture_trig_if.slave: strobe and sample in, control in, status out, read port
module adc_capture_trig #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 10,
   parameter int PRE_TRIG = 256
) (
   input  logic               sys_clk,
   input  logic               rst,
   adc_capture_trig_if.slave  bus
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int POST_N = DEPTH - PRE_TRIG - 1;   // samples written after the trigger sample

   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
   localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT,
      S_POST,
      S_DONE
   } state_t;

   state_t            state;
   logic              samp_d;
   logic              stb;
   logic [DATA_W-1:0] last_smp;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] trig_addr;
   logic              prev_valid;
   logic              force_pend;
   logic              busy_q;
   logic              trig_q;
   logic              done_q;

   logic              capturing;
   logic              wr_en;
   logic              rise_hit;
   logic              fall_hit;
   logic              level_hit;
   logic              force_hit;
   logic              trig_hit;
   logic [ADDR_W-1:0] rd_ptr;
   logic [DATA_W-1:0] rd_q;

   logic [DATA_W-1:0] mem [DEPTH];

   // One strobe per rising edge of the divided sample clock.
   assign stb = bus.samp_clk & ~samp_d;

   // The incoming word is the newest sample, and last_smp is the one before it.
   // Evaluating on the strobe cycle itself lets state and flags settle one
   // cycle after the strobe, with no extra pipeline stage.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         samp_d   <= 1'b0;
         last_smp <= '0;
      end else begin
         samp_d <= bus.samp_clk;
         if (stb) begin
            last_smp <= bus.adc_data;
         end
      end
   end

   always_comb begin
      capturing = 1'b0;
      wr_en     = 1'b0;
      rise_hit  = 1'b0;
      fall_hit  = 1'b0;
      level_hit = 1'b0;
      force_hit = 1'b0;
      trig_hit  = 1'b0;
      rd_ptr    = '0;

      capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
      wr_en     = stb && capturing;

      rise_hit  = (last_smp < bus.trig_level) && (bus.adc_data >= bus.trig_level);
      fall_hit  = (last_smp > bus.trig_level) && (bus.adc_data <= bus.trig_level);
      level_hit = prev_valid && (bus.trig_slope ? rise_hit : fall_hit);
      // A force pulse that lands on the strobe cycle itself also counts.
      force_hit = force_pend || bus.force_trig;
      trig_hit  = level_hit || force_hit;

      // Record index 0 is PRE_TRIG samples ahead of the trigger; ADDR_W-bit wrap is intended.
      rd_ptr    = trig_addr - PRE_OFS + bus.rd_addr;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         cnt        <= '0;
         trig_addr  <= '0;
         prev_valid <= 1'b0;
         force_pend <= 1'b0;
         busy_q     <= 1'b0;
         trig_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.arm) begin
                  state      <= S_PRE;
                  cnt        <= '0;
                  prev_valid <= 1'b0;
                  force_pend <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end

            // Fill the pre-trigger history; crossings here are deliberately ignored.
            S_PRE: begin
               if (stb) begin
                  wr_ptr     <= wr_ptr + 1'b1;
                  prev_valid <= 1'b1;
                  if (cnt == PRE_LAST) begin
                     state <= S_WAIT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            // The ring keeps overwriting while waiting, so the last PRE_TRIG
            // samples before the trigger are always fresh.
            S_WAIT: begin
               if (bus.force_trig) begin
                  force_pend <= 1'b1;
               end
               if (stb) begin
                  wr_ptr     <= wr_ptr + 1'b1;
                  prev_valid <= 1'b1;
                  if (trig_hit) begin
                     trig_addr  <= wr_ptr;
                     trig_q     <= 1'b1;
                     force_pend <= 1'b0;
                     cnt        <= '0;
                     state      <= S_POST;
                  end
               end
            end

            S_POST: begin
               if (stb) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (cnt == POST_LAST) begin
                     state  <= S_DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            // Record frozen: no writes until re-armed.
            S_DONE: begin
               if (bus.arm) begin
                  state      <= S_PRE;
                  cnt        <= '0;
                  prev_valid <= 1'b0;
                  force_pend <= 1'b0;
                  busy_q     <= 1'b1;
                  trig_q     <= 1'b0;
                  done_q     <= 1'b0;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Sample memory: one write port, one read port. Nonblocking update gives
   // read-old-data on an address collision, and contents survive reset.
   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= bus.adc_data;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         rd_q <= '0;
      end else begin
         rd_q <= mem[rd_ptr];
      end
   end

   assign bus.busy      = busy_q;
   assign bus.triggered = trig_q;
   assign bus.done      = done_q;
   assign bus.rd_data   = rd_q;

endmodule
